piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the single-bit flop-chain links used in this design.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a registered serial line, one bit per clock.
- Framing strobes mark the first and last bit of each word.
- Supports zero-gap back-to-back words, so a downstream serial-to-parallel receiver sees a continuous stream.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  word to transmit; sampled only on accept.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  transmitter can accept a word this cycle.
- ser_out  output  1  serial data bit (registered).
- ser_valid  output  1  ser_out carries a valid bit (registered).
- ser_first  output  1  high with bit 0 of a word in transmit order (registered).
- ser_last  output  1  high with the final bit of a word (registered).
- busy  output  1  a word is in flight (registered).

Behaviour:
- Reset is asynchronous and active-high on clk.
- While reset is high:
  - ser_out, ser_valid, ser_first, ser_last and busy are 0.
  - in_ready is 0 (gated combinationally with reset).
  - The state is IDLE, the bit counter is 0 and the shift register is 0.
- Reset asserted mid-word aborts the word immediately. Nothing resumes after release; the first cycle after release is IDLE with in_ready = 1.
- State machine has two states, IDLE and SHIFT. Internal signals: shift register sr[WIDTH-1:0] and counter cnt[$clog2(WIDTH)-1:0].
- Accept is in_valid && in_ready at a rising edge. There is no other way to load a word.
- in_ready = !reset && (state == IDLE || (state == SHIFT && cnt == WIDTH-1)). It is combinational from state, with no path from in_valid.
- IDLE:
  - On accept: the first bit of data_in goes to ser_out; ser_valid = 1, ser_first = 1, ser_last = 0, busy = 1.
  - The remaining bits load into sr; cnt = 0; next state is SHIFT.
  - Without accept: all serial outputs stay 0.
- SHIFT with cnt < WIDTH-1:
  - At each edge, ser_out = next bit in transmit order, cnt increments, ser_first = 0.
  - ser_last = 1 on the edge where cnt becomes WIDTH-1.
  - in_valid is ignored; upstream holds data_in and in_valid until in_ready.
- SHIFT with cnt == WIDTH-1 (last bit on the line, in_ready = 1):
  - On accept: behaves like the IDLE accept. The next word's first bit follows with no gap (ser_first = 1, ser_last = 0), cnt = 0, state stays SHIFT.
  - Without accept: ser_out, ser_valid, ser_first, ser_last and busy all go to 0; next state is IDLE.
- Latency and rate:
  - The first bit is on ser_out the cycle after the accept edge.
  - A word occupies exactly WIDTH consecutive ser_valid cycles.
  - Peak throughput is one bit per clock.
- Bit order:
  - MSB_FIRST = 1: data_in[WIDTH-1] down to data_in[0].
  - MSB_FIRST = 0: data_in[0] up to data_in[WIDTH-1].
- ser_out is 0 whenever ser_valid = 0.
- ser_first and ser_last are never high in the same cycle (WIDTH ≥ 2).
- data_in changes while not accepting have no effect.

Test Plan:
- Single word 0xA5, MSB_FIRST = 1, one-cycle in_valid pulse:
  - 8 ser_valid cycles with ser_out = 1,0,1,0,0,1,0,1.
  - ser_first on bit 1, ser_last on bit 8.
  - in_ready = 0 for bits 1..7 and 1 during bit 8.
  - Afterwards ser_valid = 0, busy = 0.
- Back-to-back 0xA5 then 0x3C, in_valid held high:
  - 16 contiguous ser_valid cycles with bits 10100101 00111100.
  - ser_first at cycles 1 and 9, ser_last at cycles 8 and 16, no idle gap.
- MSB_FIRST = 0, word 0x01: ser_out = 1,0,0,0,0,0,0,0.
- Held request while busy: in_valid asserted from bit 2 with data 0xFF. It is not accepted until the last-bit cycle of the current word, then 0xFF streams with no gap.
- Reset mid-word: assert reset after 3 bits of 0xA5.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, in_ready = 1; a new word 0x0F transmits cleanly as 0,0,0,0,1,1,1,1.
- WIDTH = 2, words 0b10 then 0b01 back-to-back: ser_out = 1,0,0,1; ser_first and ser_last alternate each cycle.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter.
// Accepts a WIDTH-bit word over valid/ready and shifts it onto a registered
// serial line one bit per clock, with first/last framing strobes. A new word
// can be accepted during the last bit of the current one, so consecutive
// words stream with no idle gap.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   data_in    word to transmit, sampled only on accept
//   in_valid   data_in is valid
//   in_ready   a word can be accepted this cycle (combinational from state)
//   ser_out    serial data bit (registered, 0 when ser_valid is 0)
//   ser_valid  ser_out carries a valid bit (registered)
//   ser_first  first bit of a word in transmit order (registered)
//   ser_last   final bit of a word (registered)
//   busy       a word is in flight (registered)
module piso_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned    CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  LAST_M1 = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  logic             at_last;
  logic             accept;
  logic             load_bit;
  logic [WIDTH-1:0] load_rest;
  logic             next_bit;
  logic [WIDTH-1:0] sr_shifted;

  assign at_last  = (state == SHIFT) && (cnt == LAST);
  assign in_ready = !reset && ((state == IDLE) || at_last);
  assign accept   = in_valid && in_ready;

  // The first bit goes straight to the line; the remaining bits are parked
  // in sr aligned so that the shift end always holds the next bit to send.
  always_comb begin
    load_bit   = 1'b0;
    load_rest  = '0;
    next_bit   = 1'b0;
    sr_shifted = '0;
    if (MSB_FIRST) begin
      load_bit   = data_in[WIDTH-1];
      load_rest  = data_in << 1;
      next_bit   = sr[WIDTH-1];
      sr_shifted = sr << 1;
    end else begin
      load_bit   = data_in[0];
      load_rest  = data_in >> 1;
      next_bit   = sr[0];
      sr_shifted = sr >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      // Same path from IDLE and from the last bit of a word: back-to-back
      // words need no separate handling.
      state     <= SHIFT;
      sr        <= load_rest;
      cnt       <= '0;
      ser_out   <= load_bit;
      ser_valid <= 1'b1;
      ser_first <= 1'b1;
      ser_last  <= 1'b0;
      busy      <= 1'b1;
    end else if (state == SHIFT && !at_last) begin
      sr        <= sr_shifted;
      cnt       <= cnt + 1'b1;
      ser_out   <= next_bit;
      ser_first <= 1'b0;
      ser_last  <= (cnt == LAST_M1);
    end else if (state == SHIFT) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed bench for piso_tx with a bit-level scoreboard.
// Three instances: WIDTH=8 MSB first, WIDTH=8 LSB first, WIDTH=2 MSB first.
// Expected bits are pushed when a word is handed over and popped as the
// serial line presents them.
module tb_piso_tx;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  logic clk;
  logic reset;

  logic [7:0] din_a, din_b;
  logic [1:0] din_c;
  logic       iv_a, iv_b, iv_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic       so_a, so_b, so_c;
  logic       sv_a, sv_b, sv_c;
  logic       sf_a, sf_b, sf_c;
  logic       sl_a, sl_b, sl_c;
  logic       bz_a, bz_b, bz_c;

  exp_t q[3][$];
  int   n_assert;
  int   n_fail;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .data_in(din_a), .in_valid(iv_a), .in_ready(rdy_a),
    .ser_out(so_a), .ser_valid(sv_a), .ser_first(sf_a), .ser_last(sl_a), .busy(bz_a)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .data_in(din_b), .in_valid(iv_b), .in_ready(rdy_b),
    .ser_out(so_b), .ser_valid(sv_b), .ser_first(sf_b), .ser_last(sl_b), .busy(bz_b)
  );

  piso_tx #(.WIDTH(2), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(reset), .data_in(din_c), .in_valid(iv_c), .in_ready(rdy_c),
    .ser_out(so_c), .ser_valid(sv_c), .ser_first(sf_c), .ser_last(sl_c), .busy(bz_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Per-cycle check of one instance against its scoreboard queue.
  task automatic check_dut(input int d, input logic so, input logic sv, input logic sf,
                           input logic sl, input logic bz, input logic rdy);
    exp_t  e;
    string p;
    p = $sformatf("dut%0d", d);
    chk({p, "_valid"}, sv, q[d].size() != 0);
    chk({p, "_busy"}, bz, q[d].size() != 0);
    if (q[d].size() != 0) begin
      e = q[d].pop_front();
      chk({p, "_bit"}, so, e.b);
      chk({p, "_first"}, sf, e.f);
      chk({p, "_last"}, sl, e.l);
    end else begin
      chk({p, "_idle_bit"}, so, 1'b0);
      chk({p, "_idle_first"}, sf, 1'b0);
      chk({p, "_idle_last"}, sl, 1'b0);
    end
    // Ready exactly when nothing more is owed after the bit now on the line.
    chk({p, "_ready"}, rdy, !reset && q[d].size() == 0);
  endtask

  always begin
    @(posedge clk);
    #3;
    check_dut(0, so_a, sv_a, sf_a, sl_a, bz_a, rdy_a);
    check_dut(1, so_b, sv_b, sf_b, sl_b, bz_b, rdy_b);
    check_dut(2, so_c, sv_c, sf_c, sl_c, bz_c, rdy_c);
  end

  task automatic set_in(input int d, input logic v, input logic [7:0] w);
    case (d)
      0:       begin iv_a = v; din_a = w;      end
      1:       begin iv_b = v; din_b = w;      end
      default: begin iv_c = v; din_c = w[1:0]; end
    endcase
  endtask

  function automatic logic get_rdy(input int d);
    case (d)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  // Called at posedge+1. Presents the word, and on the cycle it will be
  // accepted pushes its bits; returns at posedge+1 after the accept edge
  // with in_valid dropped.
  task automatic send(input int d, input logic [7:0] w);
    int   wd;
    logic msb;
    bit   done;
    exp_t e;
    wd   = (d == 2) ? 2 : 8;
    msb  = (d != 1);
    done = 0;
    set_in(d, 1'b1, w);
    for (int c = 0; c < 40 && !done; c++) begin
      #4;
      if (get_rdy(d)) begin
        for (int i = 0; i < wd; i++) begin
          e.b = msb ? w[wd-1-i] : w[i];
          e.f = (i == 0);
          e.l = (i == wd - 1);
          q[d].push_back(e);
        end
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk($sformatf("dut%0d_accept_timeout", d), 1'b0, 1'b1);
    set_in(d, 1'b0, 8'h00);
  endtask

  task automatic wait_drain(input int d);
    for (int c = 0; c < 40 && q[d].size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("dut%0d_drained", d), q[d].size() == 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    din_a = 8'h00; din_b = 8'h00; din_c = 2'b00;
    #1;
    chk("rst_ser_valid", sv_a, 1'b0);
    chk("rst_in_ready", rdy_a, 1'b0);
    chk("rst_busy", bz_a, 1'b0);
    repeat (2) @(posedge clk);
    #5 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", rdy_a, 1'b1);

    // Single word, one-cycle pulse.
    send(0, 8'hA5);
    wait_drain(0);

    // Back-to-back with in_valid held.
    send(0, 8'hA5);
    send(0, 8'h3C);
    wait_drain(0);

    // LSB first.
    send(1, 8'h01);
    wait_drain(1);

    // Request raised at bit 2 waits for the last-bit cycle, then no gap.
    send(0, 8'hA5);
    @(posedge clk);
    #1;
    send(0, 8'hFF);
    wait_drain(0);

    // Changing data_in without valid must not start anything.
    din_a = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    din_a = 8'h00;

    // Reset after three bits aborts immediately, before any clock edge.
    send(0, 8'hA5);
    repeat (2) @(posedge clk);
    #4;
    reset = 1'b1;
    q[0].delete();
    #1;
    chk("async_rst_valid", sv_a, 1'b0);
    chk("async_rst_out", so_a, 1'b0);
    chk("async_rst_first", sf_a, 1'b0);
    chk("async_rst_last", sl_a, 1'b0);
    chk("async_rst_busy", bz_a, 1'b0);
    chk("async_rst_ready", rdy_a, 1'b0);
    @(posedge clk);
    #5 reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release_ready", rdy_a, 1'b1);
    send(0, 8'h0F);
    wait_drain(0);

    // WIDTH=2 back-to-back.
    send(2, 8'h02);
    send(2, 8'h01);
    wait_drain(2);

    repeat (3) @(posedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
